// File: rtl/ulpi_stream_packer_if.sv
// rtl/ulpi_stream_packer_if.sv - ULPI receive item input and escaped byte output bundle for ulpi_stream_packer
interface ulpi_stream_packer_if;
    logic [7:0] IN_DATA;
    logic       IN_RXCMD;
    logic       IN_VALID;
    logic       IN_READY;
    logic [7:0] OUT_DATA;
    logic       OUT_WR;
    logic       OUT_HAVE_SPACE;
    logic       OVERFLOW;

    modport master (
        output IN_DATA, IN_RXCMD, IN_VALID, OUT_HAVE_SPACE,
        input  IN_READY, OUT_DATA, OUT_WR, OVERFLOW
    );

    modport slave (
        input  IN_DATA, IN_RXCMD, IN_VALID, OUT_HAVE_SPACE,
        output IN_READY, OUT_DATA, OUT_WR, OVERFLOW
    );
endinterface

// File: rtl/ulpi_stream_packer.sv
// rtl/ulpi_stream_packer.sv - FIFO-buffered ULPI data/RXCMD to escaped byte stream packer
// Define ULPI_STREAM_PACKER_OVF_MARKER_EN to emit an ESC,02 marker after dropped input items.
module ulpi_stream_packer #(
    parameter int         FIFO_DEPTH_LOG2 = 4,
    parameter logic [7:0] ESC_BYTE        = 8'hA0
) (
    input logic              CLK,
    input logic              RST,
    ulpi_stream_packer_if.slave bus
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0] PTR_ONE = {{FIFO_DEPTH_LOG2{1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        ESC_HDR,
        ESC_CODE,
        RXCMD_VAL
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
        , OVF_HDR,
        OVF_CODE
`endif
    } state_t;

    state_t state, next;

    logic [8:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic                       full, empty, push, drop, pop;
    logic [8:0]                 head;
    logic                       item_rxcmd;
    logic [7:0]                 item_data;
    logic                       latch_item, load;
    logic [7:0]                 load_byte;

    assign full  = (wr_ptr[FIFO_DEPTH_LOG2] != rd_ptr[FIFO_DEPTH_LOG2]) &&
                   (wr_ptr[FIFO_DEPTH_LOG2-1:0] == rd_ptr[FIFO_DEPTH_LOG2-1:0]);
    assign empty = (wr_ptr == rd_ptr);
    // A full FIFO drops the offered item even when a pop frees a slot on the same edge.
    assign push  = bus.IN_VALID && !full;
    assign drop  = bus.IN_VALID && full;
    assign head  = mem[rd_ptr[FIFO_DEPTH_LOG2-1:0]];
    assign bus.IN_READY = !full;

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr[FIFO_DEPTH_LOG2-1:0]] <= {bus.IN_RXCMD, bus.IN_DATA};
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            bus.OVERFLOW <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (drop) bus.OVERFLOW <= 1'b1;
        end
    end

`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
    logic ovf_pending, ovf_clr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)          ovf_pending <= 1'b0;
        else if (drop)    ovf_pending <= 1'b1;
        else if (ovf_clr) ovf_pending <= 1'b0;
    end
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            item_rxcmd <= 1'b0;
            item_data  <= 8'h00;
        end else begin
            state <= next;
            if (latch_item) begin
                item_rxcmd <= head[8];
                item_data  <= head[7:0];
            end
        end
    end

    // The output register only changes on edges where the streamer has space, which
    // is also the edge any held byte transfers; otherwise OUT_DATA/OUT_WR hold.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            bus.OUT_WR   <= 1'b0;
            bus.OUT_DATA <= 8'h00;
        end else if (bus.OUT_HAVE_SPACE) begin
            bus.OUT_WR <= load;
            if (load) bus.OUT_DATA <= load_byte;
        end
    end

    // IDLE only peeks at the FIFO head; the item is popped when its first byte loads,
    // so an item waiting on a stalled streamer still occupies its FIFO slot.
    always_comb begin
        next       = state;
        pop        = 1'b0;
        load       = 1'b0;
        load_byte  = 8'h00;
        latch_item = 1'b0;
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
        ovf_clr    = 1'b0;
`endif
        case (state)
            IDLE: begin
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
                if (ovf_pending) next = OVF_HDR;
                else
`endif
                if (!empty) next = (head[8] || head[7:0] == ESC_BYTE) ? ESC_HDR : DATA;
            end
            DATA: begin
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
                if (ovf_pending) next = OVF_HDR;
                else
`endif
                if (bus.OUT_HAVE_SPACE) begin
                    load      = 1'b1;
                    load_byte = head[7:0];
                    pop       = 1'b1;
                    next      = IDLE;
                end
            end
            ESC_HDR: begin
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
                if (ovf_pending) next = OVF_HDR;
                else
`endif
                if (bus.OUT_HAVE_SPACE) begin
                    load       = 1'b1;
                    load_byte  = ESC_BYTE;
                    pop        = 1'b1;
                    latch_item = 1'b1;
                    next       = ESC_CODE;
                end
            end
            ESC_CODE: begin
                if (bus.OUT_HAVE_SPACE) begin
                    load      = 1'b1;
                    load_byte = item_rxcmd ? 8'h01 : 8'h00;
                    next      = item_rxcmd ? RXCMD_VAL : IDLE;
                end
            end
            RXCMD_VAL: begin
                if (bus.OUT_HAVE_SPACE) begin
                    load      = 1'b1;
                    load_byte = item_data;
                    next      = IDLE;
                end
            end
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
            OVF_HDR: begin
                if (bus.OUT_HAVE_SPACE) begin
                    load      = 1'b1;
                    load_byte = ESC_BYTE;
                    next      = OVF_CODE;
                end
            end
            OVF_CODE: begin
                if (bus.OUT_HAVE_SPACE) begin
                    load      = 1'b1;
                    load_byte = 8'h02;
                    ovf_clr   = 1'b1;
                    next      = IDLE;
                end
            end
`endif
            default: next = IDLE;
        endcase
    end
endmodule

// File: tb/tb_ulpi_stream_packer.sv
// tb/tb_ulpi_stream_packer.sv - scoreboard bench for ulpi_stream_packer
module tb_ulpi_stream_packer;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    ulpi_stream_packer_if bus();

    ulpi_stream_packer #(.FIFO_DEPTH_LOG2(4), .ESC_BYTE(8'hA0)) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void expect_item(input logic rx, input logic [7:0] d);
        if (rx) begin
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'h01);
            exp_q.push_back(d);
        end else if (d == 8'hA0) begin
            exp_q.push_back(8'hA0);
            exp_q.push_back(8'h00);
        end else begin
            exp_q.push_back(d);
        end
    endfunction

    // Every transfer is compared against the head of the expected stream.
    always @(negedge CLK) begin
        if (!RST && bus.OUT_WR && bus.OUT_HAVE_SPACE) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'h0, bus.OUT_DATA}, 32'h100);
            else chk("out_byte", {24'h0, bus.OUT_DATA}, {24'h0, exp_q.pop_front()});
        end
    end

    task automatic send(input logic rx, input logic [7:0] d, input bit exp_it);
        bus.IN_VALID = 1'b1;
        bus.IN_RXCMD = rx;
        bus.IN_DATA  = d;
        if (exp_it) expect_item(rx, d);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge CLK);
        repeat (6) @(posedge CLK);
        #1;
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_out_wr(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge CLK);
            #1;
            if (bus.OUT_WR) seen = 1'b1;
        end
        chk(tag, {31'h0, seen}, 1);
    endtask

    initial begin
        bus.IN_VALID       = 1'b0;
        bus.IN_RXCMD       = 1'b0;
        bus.IN_DATA        = 8'h00;
        bus.OUT_HAVE_SPACE = 1'b1;
        RST                = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_out_wr",   {31'h0, bus.OUT_WR},   0);
        chk("rst_out_data", {24'h0, bus.OUT_DATA}, 0);
        chk("rst_overflow", {31'h0, bus.OVERFLOW}, 0);
        chk("rst_in_ready", {31'h0, bus.IN_READY}, 1);
        RST = 1'b0;

        // 11,A0,22 back to back; first push lands on the first edge after release.
        bus.IN_VALID = 1'b1; bus.IN_RXCMD = 1'b0; bus.IN_DATA = 8'h11;
        expect_item(1'b0, 8'h11);
        @(posedge CLK); #1;
        bus.IN_DATA = 8'hA0;
        expect_item(1'b0, 8'hA0);
        chk("lat_n0", {31'h0, bus.OUT_WR}, 0);
        @(posedge CLK); #1;
        bus.IN_DATA = 8'h22;
        expect_item(1'b0, 8'h22);
        chk("lat_n1", {31'h0, bus.OUT_WR}, 0);
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
        chk("lat_n2_wr",   {31'h0, bus.OUT_WR},   1);
        chk("lat_n2_data", {24'h0, bus.OUT_DATA}, 32'h11);
        drain();

        // RXCMD with a five-cycle stall after the header byte.
        send(1'b1, 8'h4E, 1'b1);
        wait_out_wr("rx_wait_hdr");
        chk("rx_hdr", {24'h0, bus.OUT_DATA}, 32'hA0);
        @(posedge CLK); #1;
        bus.OUT_HAVE_SPACE = 1'b0;
        chk("rx_code", {24'h0, bus.OUT_DATA}, 32'h01);
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK); #1;
            chk("hold_wr",   {31'h0, bus.OUT_WR},   1);
            chk("hold_data", {24'h0, bus.OUT_DATA}, 32'h01);
        end
        bus.OUT_HAVE_SPACE = 1'b1;
        drain();

        // Overflow: streamer stalled, 20 pushes into a 16-deep FIFO.
        bus.OUT_HAVE_SPACE = 1'b0;
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
        exp_q.push_back(8'hA0);
        exp_q.push_back(8'h02);
`endif
        for (int i = 0; i < 20; i++) begin
            send(1'b0, 8'(i), i < 16);
            if (i == 14) chk("ready_at_15", {31'h0, bus.IN_READY}, 1);
            if (i == 15) chk("ready_at_16", {31'h0, bus.IN_READY}, 0);
        end
        chk("ovf_ready_low", {31'h0, bus.IN_READY}, 0);
        chk("ovf_sticky",    {31'h0, bus.OVERFLOW}, 1);
        chk("ovf_no_wr",     {31'h0, bus.OUT_WR},   0);
        // Push on the release edge while the FIFO is full: dropped despite the pop.
        bus.IN_VALID = 1'b1; bus.IN_DATA = 8'h77; bus.OUT_HAVE_SPACE = 1'b1;
        @(posedge CLK); #1;
        bus.IN_VALID = 1'b0;
`ifdef ULPI_STREAM_PACKER_OVF_MARKER_EN
        chk("full_push_pop_ready", {31'h0, bus.IN_READY}, 0);
`else
        chk("full_push_pop_ready", {31'h0, bus.IN_READY}, 1);
`endif
        drain();
        chk("ovf_still_set", {31'h0, bus.OVERFLOW}, 1);

        // Reset while the RXCMD escape code is pending.
        send(1'b1, 8'h4E, 1'b1);
        wait_out_wr("rst_wait_hdr");
        bus.OUT_HAVE_SPACE = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        chk("mid_rst_wr",    {31'h0, bus.OUT_WR},   0);
        chk("mid_rst_ovf",   {31'h0, bus.OVERFLOW}, 0);
        chk("mid_rst_ready", {31'h0, bus.IN_READY}, 1);
        exp_q.delete();
        @(posedge CLK); #1;
        RST = 1'b0;
        bus.OUT_HAVE_SPACE = 1'b1;
        send(1'b0, 8'h55, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
